ram_mfc_controller: RTL and testbench
=====================================

# ram_mfc_controller

Byte-addressed 256×8 program/data memory with an MFA/MFC request–complete handshake. It sits directly downstream of the data path's memory address register (MAR) and memory data register (MDR), and returns MFC to the control unit. Storage is big-endian: the most significant byte of a word is at the lowest address. Accesses take a fixed, parameterised latency so the control unit's wait states are exercised.

## Interface
- LATENCY, 3: cycles from MFA acceptance to MFC assertion. Legal range is 1–15.
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- MFA  in  1  memory function activate; request strobe, level-held by the control unit.
- RW  in  1  1 = write, 0 = read.
- TYPE  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- ADDR  in  8  byte address, driven from MAR.
- DATA_IN  in  32  write data from MDR; right-justified for byte and halfword.
- DATA_OUT  out  32  read data, zero-extended.
- MFC  out  1  memory function complete.
- BUSY  out  1  high in WAIT and DONE.
- MISALIGN  out  1  alignment error flag; see Configuration.

## Operation
- The array `Mem[0:255]` is 8 bits wide and is hierarchically preloadable by testbenches.
  - Reset does not clear it.
  - Reset does not gate testbench preload.
- FSM states are IDLE, WAIT and DONE. A 4-bit down-counter `cnt` drives the WAIT state.
- **IDLE:** if MFA = 1 at a rising edge:
  - latch ADDR, RW, TYPE and DATA_IN into request registers;
  - load `cnt = LATENCY-1`;
  - go to WAIT.
- **WAIT:**
  - Decrement `cnt` each edge.
  - Input changes are ignored; the latched request is used.
  - At the edge where `cnt == 0`, perform the access, set MFC = 1 and go to DONE.
  - If MFA drops during WAIT, the access still completes; DONE then exits on the next edge.
- **Access (a = latched address, all index arithmetic mod 256):**
  - Word read: `DATA_OUT = {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}`.
  - Halfword read: `{16'h0, Mem[a], Mem[a+1]}`.
  - Byte read: `{24'h0, Mem[a]}`.
  - Writes store the low-order bytes of DATA_IN in the same order.
  - DATA_OUT is unchanged on a write.
- **Address wrap:** a word at 0xFE writes Mem[FE], Mem[FF], Mem[00], Mem[01].
- **DONE:**
  - MFC and DATA_OUT are held while MFA = 1.
  - When MFA = 0 at an edge, clear MFC and go to IDLE.
  - A new request needs MFA = 0 to be seen in DONE first. There is no back-to-back pipelining.
- **Reset (asynchronous):** state = IDLE, MFC = 0, BUSY = 0, MISALIGN = 0, DATA_OUT = 0, `cnt` = 0.
  - Reset during WAIT aborts the request; no memory write occurs.

## Timing
- Request accepted at edge k → MFC rises after edge k+LATENCY. DATA_OUT is valid in the same cycle.
- MFC falls after the first edge at which MFA = 0 in DONE.
- The earliest next acceptance is the edge after that.
- Minimum cycle per access is LATENCY+2 edges, counting MFA drop and re-raise by the control unit.
- BUSY rises after edge k and falls together with MFC.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `RAM_ALIGN_CHECK_EN`.
- **Defined:**
  - An access is misaligned when it is a halfword with `a[0] = 1`, or a word/reserved type with `a[1:0] ≠ 00`.
  - On a misaligned access, the FSM still runs the full latency and MFC asserts normally.
  - No memory write occurs and DATA_OUT is forced to 0.
  - MISALIGN = 1 from MFC rise until MFC falls.
- **Undefined:**
  - Misaligned accesses proceed with wrap-around as described above.
  - MISALIGN is tied to 0.

## Test plan
- **Reset:** preload Mem[0..3] = 12,34,56,78; pulse Reset mid-cycle with no clock edge → MFC = 0, DATA_OUT = 0, and Mem is unchanged.
- **Word read:** word read at ADDR 0x00 with LATENCY = 3, MFA accepted at edge k → MFC = 0 through edge k+2; MFC = 1 after edge k+3 with DATA_OUT = 0x12345678; MFC held until MFA = 0.
- **Byte write then word read:** byte write of DATA_IN = 0xFFFFFFAB at 0x41, then word read at 0x40 (Mem[0x40..0x43] = 0) → DATA_OUT = 0x00AB0000.
- **Halfword write, wrap-around:** halfword write of 0xBEEF at 0xFF, with `RAM_ALIGN_CHECK_EN` undefined → Mem[FF] = BE, Mem[00] = EF; halfword read at 0xFF returns 0x0000BEEF.
- **Misalignment check:** with `RAM_ALIGN_CHECK_EN` defined, word write of 0xDEADBEEF at 0x02 → MFC asserts after LATENCY, MISALIGN = 1, and Mem[02..05] is unchanged.
- **Reset mid-WAIT:** assert Reset one cycle after accepting a word write of 0xCAFEF00D at 0x10 → no write occurs; after release, a word read at 0x10 returns the prior contents.

Source files
------------

// File: rtl/ram_mfc_controller.sv
//------------------------------------------------------------------------------
// Module  : ram_mfc_controller
// Purpose : 256x8 big-endian memory with MFA/MFC handshake and fixed latency.
//           Optional alignment checking is enabled by defining RAM_ALIGN_CHECK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_mfc_controller #(
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mfa_i,
    input  logic        rw_i,
    input  logic [1:0]  type_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        mfc_o,
    output logic        busy_o,
    output logic        misalign_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [7:0]      Mem [0:255];

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      addr_q;
    logic            rw_q;
    logic [1:0]      type_q;
    logic [31:0]     wdata_q;
    logic [31:0]     data_out_q, data_out_d;
    logic            mfc_q, mfc_d;

    logic            w_accept;
    logic            w_access;
    logic            w_misalign;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_rd_data;
    logic [3:0]      w_we;
    logic [3:0][7:0] w_wb;

    assign w_accept = (state_q == S_IDLE) && mfa_i;
    assign w_access = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Index arithmetic wraps naturally in 8 bits.
    assign w_rd_word = {Mem[addr_q], Mem[addr_q + 8'd1],
                        Mem[addr_q + 8'd2], Mem[addr_q + 8'd3]};

    always_comb begin
        case (type_q)
            2'b00:   w_rd_data = {24'h0, w_rd_word[31:24]};
            2'b01:   w_rd_data = {16'h0, w_rd_word[31:16]};
            default: w_rd_data = w_rd_word;
        endcase
    end

`ifdef RAM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        case (type_q)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = addr_q[0];
            default: w_misalign = (addr_q[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        misalign_d = 1'b0;
        if (w_access) begin
            misalign_d = w_misalign;
        end else if ((state_q == S_DONE) && mfa_i) begin
            misalign_d = misalign_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign w_misalign = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // Lane i targets address a+i and takes the (n-1-i)th byte of the write data.
    always_comb begin
        w_we = 4'b0000;
        w_wb = '0;
        case (type_q)
            2'b00: begin
                w_we    = 4'b0001;
                w_wb[0] = wdata_q[7:0];
            end
            2'b01: begin
                w_we    = 4'b0011;
                w_wb[0] = wdata_q[15:8];
                w_wb[1] = wdata_q[7:0];
            end
            default: begin
                w_we    = 4'b1111;
                w_wb[0] = wdata_q[31:24];
                w_wb[1] = wdata_q[23:16];
                w_wb[2] = wdata_q[15:8];
                w_wb[3] = wdata_q[7:0];
            end
        endcase
        if (!(w_access && rw_q) || w_misalign) begin
            w_we = 4'b0000;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we[i]) begin
                Mem[addr_q + 8'(i)] <= w_wb[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            data_out_q <= 32'h0;
            mfc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            mfc_q      <= mfc_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= 8'h0;
            rw_q    <= 1'b0;
            type_q  <= 2'b00;
            wdata_q <= 32'h0;
        end else if (w_accept) begin
            addr_q  <= addr_i;
            rw_q    <= rw_i;
            type_q  <= type_i;
            wdata_q <= data_in_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mfa_i) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:  if (!mfa_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        mfc_d      = 1'b0;
        if (w_accept) begin
            cnt_d = 4'(LATENCY - 1);
        end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (w_access) begin
            mfc_d = 1'b1;
            if (w_misalign) begin
                data_out_d = 32'h0;
            end else if (!rw_q) begin
                data_out_d = w_rd_data;
            end
        end else if ((state_q == S_DONE) && mfa_i) begin
            mfc_d = 1'b1;
        end
    end

    assign data_out_o = data_out_q;
    assign mfc_o      = mfc_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_mfc_controller.sv
//------------------------------------------------------------------------------
// Module  : tb_ram_mfc_controller
// Purpose : Directed self-checking bench for ram_mfc_controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_mfc_controller;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mfa;
    logic        rw;
    logic [1:0]  ty;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mfc;
    logic        busy;
    logic        mis;

    int checks   = 0;
    int failures = 0;

    ram_mfc_controller #(.LATENCY(LAT)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mfa_i      (mfa),
        .rw_i       (rw),
        .type_i     (ty),
        .addr_i     (addr),
        .data_in_i  (din),
        .data_out_o (dout),
        .mfc_o      (mfc),
        .busy_o     (busy),
        .misalign_o (mis)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Runs one full handshake; lat counts edges from acceptance edge to MFC seen.
    task automatic access(input logic w, input logic [1:0] t, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output int lat, output logic m, output logic busy_after);
        @(negedge clk);
        mfa = 1'b1; rw = w; ty = t; addr = a; din = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mfc && lat < 40);
        rd = dout;
        m  = mis;
        @(negedge clk);
        mfa = 1'b0; rw = 1'b0; ty = 2'b00; addr = 8'h0; din = 32'h0;
        @(posedge clk); #1;
        busy_after = mfc | busy | mis;
    endtask

    task automatic test_reset_init;
        rst = 1'b1; mfa = 1'b0; rw = 1'b0; ty = 2'b00; addr = 8'h0; din = 32'h0;
        for (int i = 0; i < 256; i++) dut.Mem[i] <= 8'h00;
        #1;
        dut.Mem[0] <= 8'h12; dut.Mem[1] <= 8'h34; dut.Mem[2] <= 8'h56; dut.Mem[3] <= 8'h78;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mfc, busy, mis, dout} !== 35'h0) begin
            failures++;
            $display("FAIL reset_init got mfc=%b busy=%b mis=%b dout=%h exp all 0", mfc, busy, mis, dout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_read;
        @(negedge clk);
        mfa = 1'b1; rw = 1'b0; ty = 2'b10; addr = 8'h00;
        @(posedge clk); #1;
        checks++;
        if (mfc !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL word_read_accept got mfc=%b busy=%b exp mfc=0 busy=1", mfc, busy);
        end
        // Latched request must ignore these changes.
        addr = 8'h55; rw = 1'b1; ty = 2'b00; din = 32'hFFFF_FFFF;
        for (int e = 1; e < LAT; e++) begin
            @(posedge clk); #1;
            checks++;
            if (mfc !== 1'b0) begin
                failures++;
                $display("FAIL word_read_wait edge=k+%0d got mfc=%b exp 0", e, mfc);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (mfc !== 1'b1 || dout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL word_read_done got mfc=%b dout=%h exp mfc=1 dout=12345678", mfc, dout);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mfc !== 1'b1 || busy !== 1'b1 || dout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL word_read_hold got mfc=%b busy=%b dout=%h exp 1 1 12345678", mfc, busy, dout);
        end
        @(negedge clk);
        mfa = 1'b0; rw = 1'b0; ty = 2'b00; addr = 8'h0; din = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (mfc !== 1'b0 || busy !== 1'b0 || dout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL word_read_release got mfc=%b busy=%b dout=%h exp 0 0 12345678", mfc, busy, dout);
        end
        checks++;
        if (dut.Mem[8'h55] !== 8'h00) begin
            failures++;
            $display("FAIL word_read_no_stray_write got %h exp 00", dut.Mem[8'h55]);
        end
    endtask

    task automatic test_reset;
        int n;
        @(negedge clk);
        mfa = 1'b1; rw = 1'b0; ty = 2'b10; addr = 8'h00;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mfc && n < 40);
        @(negedge clk);
        #2;
        rst = 1'b1; mfa = 1'b0;
        #1;
        checks++;
        if (mfc !== 1'b0 || busy !== 1'b0 || dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_async got mfc=%b busy=%b dout=%h exp 0 0 0", mfc, busy, dout);
        end
        #1;
        rst = 1'b0;
        checks++;
        if ({dut.Mem[0], dut.Mem[1], dut.Mem[2], dut.Mem[3]} !== 32'h1234_5678) begin
            failures++;
            $display("FAIL reset_mem got %h%h%h%h exp 12345678", dut.Mem[0], dut.Mem[1], dut.Mem[2], dut.Mem[3]);
        end
    endtask

    task automatic test_byte_write_word_read;
        logic [31:0] rd;
        int          lat;
        logic        m, b;
        access(1'b1, 2'b00, 8'h41, 32'hFFFF_FFAB, rd, lat, m, b);
        checks++;
        if (lat !== LAT + 1 || rd !== 32'h0 || b !== 1'b0) begin
            failures++;
            $display("FAIL byte_write got lat=%0d dout=%h rel=%b exp lat=%0d dout=0 rel=0", lat, rd, b, LAT + 1);
        end
        access(1'b0, 2'b10, 8'h40, 32'h0, rd, lat, m, b);
        checks++;
        if (rd !== 32'h00AB_0000 || lat !== LAT + 1) begin
            failures++;
            $display("FAIL word_read_40 got dout=%h lat=%0d exp 00ab0000 lat=%0d", rd, lat, LAT + 1);
        end
    endtask

`ifndef RAM_ALIGN_CHECK_EN
    task automatic test_halfword_wrap;
        logic [31:0] rd;
        int          lat;
        logic        m, b;
        access(1'b1, 2'b01, 8'hFF, 32'h0000_BEEF, rd, lat, m, b);
        checks++;
        if (dut.Mem[8'hFF] !== 8'hBE || dut.Mem[0] !== 8'hEF || dut.Mem[1] !== 8'h34) begin
            failures++;
            $display("FAIL half_wrap_mem got FF=%h 00=%h 01=%h exp be ef 34", dut.Mem[8'hFF], dut.Mem[0], dut.Mem[1]);
        end
        access(1'b0, 2'b01, 8'hFF, 32'h0, rd, lat, m, b);
        checks++;
        if (rd !== 32'h0000_BEEF || m !== 1'b0) begin
            failures++;
            $display("FAIL half_wrap_read got dout=%h mis=%b exp 0000beef 0", rd, m);
        end
        access(1'b0, 2'b00, 8'hFF, 32'h0, rd, lat, m, b);
        checks++;
        if (rd !== 32'h0000_00BE) begin
            failures++;
            $display("FAIL byte_read_ff got %h exp 000000be", rd);
        end
        access(1'b1, 2'b10, 8'hFE, 32'h1122_3344, rd, lat, m, b);
        access(1'b0, 2'b10, 8'hFE, 32'h0, rd, lat, m, b);
        checks++;
        if (rd !== 32'h1122_3344 || dut.Mem[2] !== 8'h56 || dut.Mem[1] !== 8'h44) begin
            failures++;
            $display("FAIL word_wrap got dout=%h m1=%h m2=%h exp 11223344 44 56", rd, dut.Mem[1], dut.Mem[2]);
        end
    endtask
`else
    task automatic test_misalign;
        logic [31:0] rd;
        int          lat;
        logic        m, b;
        access(1'b1, 2'b10, 8'h02, 32'hDEAD_BEEF, rd, lat, m, b);
        checks++;
        if (lat !== LAT + 1 || m !== 1'b1 || rd !== 32'h0 || b !== 1'b0) begin
            failures++;
            $display("FAIL misalign_write got lat=%0d mis=%b dout=%h rel=%b exp %0d 1 0 0", lat, m, rd, b, LAT + 1);
        end
        checks++;
        if ({dut.Mem[2], dut.Mem[3], dut.Mem[4], dut.Mem[5]} !== 32'h5678_0000) begin
            failures++;
            $display("FAIL misalign_mem got %h%h%h%h exp 56780000", dut.Mem[2], dut.Mem[3], dut.Mem[4], dut.Mem[5]);
        end
        access(1'b0, 2'b01, 8'h01, 32'h0, rd, lat, m, b);
        checks++;
        if (m !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL misalign_half_read got mis=%b dout=%h exp 1 0", m, rd);
        end
        access(1'b0, 2'b10, 8'h00, 32'h0, rd, lat, m, b);
        checks++;
        if (m !== 1'b0 || rd !== 32'h1234_5678) begin
            failures++;
            $display("FAIL aligned_word_read got mis=%b dout=%h exp 0 12345678", m, rd);
        end
    endtask
`endif

    task automatic test_reset_mid_wait;
        logic [31:0] rd;
        int          lat;
        logic        m, b;
        dut.Mem[8'h10] <= 8'hA1; dut.Mem[8'h11] <= 8'hB2;
        dut.Mem[8'h12] <= 8'hC3; dut.Mem[8'h13] <= 8'hD4;
        @(negedge clk);
        mfa = 1'b1; rw = 1'b1; ty = 2'b10; addr = 8'h10; din = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || mfc !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_state got busy=%b mfc=%b exp 0 0", busy, mfc);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++;
        if ({dut.Mem[8'h10], dut.Mem[8'h11], dut.Mem[8'h12], dut.Mem[8'h13]} !== 32'hA1B2_C3D4) begin
            failures++;
            $display("FAIL reset_wait_mem got %h%h%h%h exp a1b2c3d4",
                     dut.Mem[8'h10], dut.Mem[8'h11], dut.Mem[8'h12], dut.Mem[8'h13]);
        end
        access(1'b0, 2'b10, 8'h10, 32'h0, rd, lat, m, b);
        checks++;
        if (rd !== 32'hA1B2_C3D4) begin
            failures++;
            $display("FAIL reset_wait_read got %h exp a1b2c3d4", rd);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        mfa = 1'b1; rw = 1'b0; ty = 2'b11; addr = 8'h10;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mfc && n < 40);
        checks++;
        if (n !== LAT + 1 || dout !== 32'hA1B2_C3D4) begin
            failures++;
            $display("FAIL reserved_read got lat=%0d dout=%h exp %0d a1b2c3d4", n, dout, LAT + 1);
        end
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mfc !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release got mfc=%b busy=%b exp 0 0", mfc, busy);
        end
        @(negedge clk);
        mfa = 1'b1; ty = 2'b00; addr = 8'h41;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mfc && n < 40);
        checks++;
        if (n !== LAT + 1 || dout !== 32'h0000_00AB) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d dout=%h exp %0d 000000ab", n, dout, LAT + 1);
        end
        @(negedge clk);
        mfa = 1'b0; ty = 2'b00; addr = 8'h0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset_init();
        test_word_read();
        test_reset();
        test_byte_write_word_read();
`ifndef RAM_ALIGN_CHECK_EN
        test_halfword_wrap();
`else
        test_misalign();
`endif
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
